// File: rtl/cache_app_arb.sv
// cache_app_arb: two-master burst arbiter sharing the application-memory
// Wishbone port between the I-cache and D-cache refill/writeback FSMs.
// One burst is granted at a time; the grant is held until the last
// acknowledge or until the granted master drops its strobe.
// Optional feature macro: CACHE_APP_ARB_RR_EN (round-robin tie break);
// without it the D-cache wins every tie.
module cache_app_arb #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             wbi_stb_i,
    input  logic [WB_AW-1:0] wbi_adr_i,
    input  logic             wbi_we_i,
    input  logic [WB_DW-1:0] wbi_dat_i,
    input  logic [3:0]       wbi_sel_i,
    input  logic [9:0]       wbi_bl_i,
    output logic [WB_DW-1:0] wbi_dat_o,
    output logic             wbi_ack_o,
    output logic             wbi_lack_o,
    input  logic             wbd_stb_i,
    input  logic [WB_AW-1:0] wbd_adr_i,
    input  logic             wbd_we_i,
    input  logic [WB_DW-1:0] wbd_dat_i,
    input  logic [3:0]       wbd_sel_i,
    input  logic [9:0]       wbd_bl_i,
    output logic [WB_DW-1:0] wbd_dat_o,
    output logic             wbd_ack_o,
    output logic             wbd_lack_o,
    output logic             wb_app_stb_o,
    output logic [WB_AW-1:0] wb_app_adr_o,
    output logic             wb_app_we_o,
    output logic [WB_DW-1:0] wb_app_dat_o,
    output logic [3:0]       wb_app_sel_o,
    output logic [9:0]       wb_app_bl_o,
    input  logic [WB_DW-1:0] wb_app_dat_i,
    input  logic             wb_app_ack_i,
    input  logic             wb_app_lack_i,
    output logic [1:0]       arb_gnt,
    output logic [9:0]       arb_beat_cnt,
    output logic             arb_burst_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } state_t;

    state_t           state_r;
    logic [1:0]       gnt_r;
    logic [WB_AW-1:0] adr_r;
    logic             we_r;
    logic [3:0]       sel_r;
    logic [9:0]       bl_r;
    logic [9:0]       beat_cnt_r;
    logic             burst_err_r;
`ifdef CACHE_APP_ARB_RR_EN
    logic             last_d_r;     // 1: D-cache won the most recent grant
`endif

    logic             pick_d_s;
    logic             cur_stb_s;
    logic [10:0]      eff_bl_s;
    logic [10:0]      beats_at_lack_s;
    logic             len_err_s;
    logic [9:0]       beat_cnt_inc_s;

    // Read data goes to both masters; only the acks are steered by the grant.
    assign wbi_dat_o     = wb_app_dat_i;
    assign wbd_dat_o     = wb_app_dat_i;
    assign arb_gnt       = gnt_r;
    assign arb_beat_cnt  = beat_cnt_r;
    assign arb_burst_err = burst_err_r;

    // Winner selection for the IDLE exit; ties resolved by the build option.
    always_comb begin
        pick_d_s = 1'b0;
        if (wbi_stb_i && wbd_stb_i) begin
`ifdef CACHE_APP_ARB_RR_EN
            pick_d_s = ~last_d_r;
`else
            pick_d_s = 1'b1;
`endif
        end else if (wbd_stb_i) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Burst-length check: beats counted so far plus the beat ending now,
    // compared in 11 bits so a saturated counter never aliases a match.
    always_comb begin
        cur_stb_s       = (state_r == ST_GNT_D) ? wbd_stb_i : wbi_stb_i;
        eff_bl_s        = (bl_r == 10'd0) ? 11'd1 : {1'b0, bl_r};
        beats_at_lack_s = {1'b0, beat_cnt_r} + {10'd0, wb_app_ack_i};
        len_err_s       = (beats_at_lack_s != eff_bl_s);
        if (beat_cnt_r == 10'h3FF) begin
            beat_cnt_inc_s = beat_cnt_r;
        end else begin
            beat_cnt_inc_s = beat_cnt_r + 10'd1;
        end
    end

    // Slave-side mux keyed on the registered grant; acks reach only the owner.
    always_comb begin
        wb_app_stb_o = 1'b0;
        wb_app_adr_o = '0;
        wb_app_we_o  = 1'b0;
        wb_app_dat_o = '0;
        wb_app_sel_o = 4'd0;
        wb_app_bl_o  = 10'd0;
        wbi_ack_o    = 1'b0;
        wbi_lack_o   = 1'b0;
        wbd_ack_o    = 1'b0;
        wbd_lack_o   = 1'b0;
        case (state_r)
            ST_GNT_I: begin
                wb_app_stb_o = wbi_stb_i;
                wb_app_adr_o = adr_r;
                wb_app_we_o  = we_r;
                wb_app_dat_o = wbi_dat_i;
                wb_app_sel_o = sel_r;
                wb_app_bl_o  = bl_r;
                wbi_ack_o    = wb_app_ack_i;
                wbi_lack_o   = wb_app_lack_i;
            end
            ST_GNT_D: begin
                wb_app_stb_o = wbd_stb_i;
                wb_app_adr_o = adr_r;
                wb_app_we_o  = we_r;
                wb_app_dat_o = wbd_dat_i;
                wb_app_sel_o = sel_r;
                wb_app_bl_o  = bl_r;
                wbd_ack_o    = wb_app_ack_i;
                wbd_lack_o   = wb_app_lack_i;
            end
            default: begin
                wb_app_stb_o = 1'b0;
            end
        endcase
    end

    // Grant FSM: latches the winner's burst attributes, counts beats,
    // releases on last-ack or strobe abort and records length errors.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 2'b00;
            adr_r       <= '0;
            we_r        <= 1'b0;
            sel_r       <= 4'd0;
            bl_r        <= 10'd0;
            beat_cnt_r  <= 10'd0;
            burst_err_r <= 1'b0;
`ifdef CACHE_APP_ARB_RR_EN
            last_d_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wbi_stb_i || wbd_stb_i) begin
                        beat_cnt_r <= 10'd0;
                        adr_r      <= pick_d_s ? wbd_adr_i : wbi_adr_i;
                        we_r       <= pick_d_s ? wbd_we_i  : wbi_we_i;
                        sel_r      <= pick_d_s ? wbd_sel_i : wbi_sel_i;
                        bl_r       <= pick_d_s ? wbd_bl_i  : wbi_bl_i;
                        state_r    <= pick_d_s ? ST_GNT_D : ST_GNT_I;
                        gnt_r      <= pick_d_s ? 2'b10 : 2'b01;
`ifdef CACHE_APP_ARB_RR_EN
                        last_d_r   <= pick_d_s;
`endif
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (wb_app_ack_i) begin
                        beat_cnt_r <= beat_cnt_inc_s;
                    end
                    if (wb_app_lack_i) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= 2'b00;
                        if (len_err_s) begin
                            burst_err_r <= 1'b1;
                        end
                    end else if (!cur_stb_s) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= 2'b00;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_app_arb.sv
// Self-checking bench for cache_app_arb. Expected values come from a small
// behavioural model: arbitration rule, beat arithmetic and a sticky error bit.
module tb_cache_app_arb;

    logic        mclk;
    logic        rst_n;
    logic        wbi_stb_i, wbd_stb_i;
    logic [31:0] wbi_adr_i, wbd_adr_i;
    logic        wbi_we_i, wbd_we_i;
    logic [31:0] wbi_dat_i, wbd_dat_i;
    logic [3:0]  wbi_sel_i, wbd_sel_i;
    logic [9:0]  wbi_bl_i, wbd_bl_i;
    logic [31:0] wbi_dat_o, wbd_dat_o;
    logic        wbi_ack_o, wbd_ack_o, wbi_lack_o, wbd_lack_o;
    logic        wb_app_stb_o;
    logic [31:0] wb_app_adr_o;
    logic        wb_app_we_o;
    logic [31:0] wb_app_dat_o;
    logic [3:0]  wb_app_sel_o;
    logic [9:0]  wb_app_bl_o;
    logic [31:0] wb_app_dat_i;
    logic        wb_app_ack_i, wb_app_lack_i;
    logic [1:0]  arb_gnt;
    logic [9:0]  arb_beat_cnt;
    logic        arb_burst_err;

    int   n_checks;
    int   n_fail;
    logic exp_err;   // model: sticky burst error
    logic last_d;    // model: most recent grant went to D

    cache_app_arb #(.WB_AW(32), .WB_DW(32)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .wbi_stb_i(wbi_stb_i), .wbi_adr_i(wbi_adr_i), .wbi_we_i(wbi_we_i),
        .wbi_dat_i(wbi_dat_i), .wbi_sel_i(wbi_sel_i), .wbi_bl_i(wbi_bl_i),
        .wbi_dat_o(wbi_dat_o), .wbi_ack_o(wbi_ack_o), .wbi_lack_o(wbi_lack_o),
        .wbd_stb_i(wbd_stb_i), .wbd_adr_i(wbd_adr_i), .wbd_we_i(wbd_we_i),
        .wbd_dat_i(wbd_dat_i), .wbd_sel_i(wbd_sel_i), .wbd_bl_i(wbd_bl_i),
        .wbd_dat_o(wbd_dat_o), .wbd_ack_o(wbd_ack_o), .wbd_lack_o(wbd_lack_o),
        .wb_app_stb_o(wb_app_stb_o), .wb_app_adr_o(wb_app_adr_o),
        .wb_app_we_o(wb_app_we_o), .wb_app_dat_o(wb_app_dat_o),
        .wb_app_sel_o(wb_app_sel_o), .wb_app_bl_o(wb_app_bl_o),
        .wb_app_dat_i(wb_app_dat_i), .wb_app_ack_i(wb_app_ack_i),
        .wb_app_lack_i(wb_app_lack_i),
        .arb_gnt(arb_gnt), .arb_beat_cnt(arb_beat_cnt), .arb_burst_err(arb_burst_err)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Tie-break rule of the arbiter in plain terms.
    function automatic logic model_pick_d(input logic i_req, input logic d_req);
        if (i_req && d_req) begin
`ifdef CACHE_APP_ARB_RR_EN
            return !last_d;
`else
            return 1'b1;
`endif
        end
        return d_req;
    endfunction

    // Drive nacks beats to the granted master; lack on the final one if asked.
    task automatic do_beats(input logic side_d, input int nacks, input logic give_lack,
                            input logic gaps, input string tag);
        logic [1:0] exp_ack;
        logic [1:0] exp_lack;
        logic [9:0] exp_cnt;
        for (int k = 1; k <= nacks; k++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                wb_app_ack_i = 1'b0;
                wb_app_lack_i = 1'b0;
                #1;
                n_checks++;
                if ({wbd_ack_o, wbi_ack_o, wbd_lack_o, wbi_lack_o} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL %s gap_ack: acks=%b expected 0000", tag,
                             {wbd_ack_o, wbi_ack_o, wbd_lack_o, wbi_lack_o});
                end
                tick();
            end
            wb_app_ack_i  = 1'b1;
            wb_app_lack_i = give_lack && (k == nacks);
            wb_app_dat_i  = $urandom;
            if (side_d) wbd_dat_i = $urandom;
            else        wbi_dat_i = $urandom;
            #1;
            exp_ack  = side_d ? 2'b10 : 2'b01;
            exp_lack = wb_app_lack_i ? exp_ack : 2'b00;
            n_checks++;
            if ({wbd_ack_o, wbi_ack_o} !== exp_ack || {wbd_lack_o, wbi_lack_o} !== exp_lack ||
                wbi_dat_o !== wb_app_dat_i || wbd_dat_o !== wb_app_dat_i ||
                wb_app_dat_o !== (side_d ? wbd_dat_i : wbi_dat_i)) begin
                n_fail++;
                $display("FAIL %s beat%0d: ack=%b lack=%b wdat=%h, required ack=%b lack=%b wdat=%h",
                         tag, k, {wbd_ack_o, wbi_ack_o}, {wbd_lack_o, wbi_lack_o}, wb_app_dat_o,
                         exp_ack, exp_lack, side_d ? wbd_dat_i : wbi_dat_i);
            end
            tick();
            exp_cnt = (k > 1023) ? 10'h3FF : 10'(k);
            n_checks++;
            if (arb_beat_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL %s cnt%0d: arb_beat_cnt=%0d expected %0d", tag, k, arb_beat_cnt, exp_cnt);
            end
        end
        wb_app_ack_i  = 1'b0;
        wb_app_lack_i = 1'b0;
    endtask

    // One uncontended burst: request, grant check, beats, release check.
    task automatic burst(input logic side_d, input logic [31:0] adr, input logic [9:0] bl,
                         input int nacks, input logic gaps, input string tag);
        logic       we;
        logic [3:0] sel;
        int         eff;
        we  = 1'($urandom);
        sel = 4'($urandom);
        if (side_d) begin
            wbd_stb_i = 1'b1; wbd_adr_i = adr; wbd_we_i = we; wbd_sel_i = sel; wbd_bl_i = bl;
        end else begin
            wbi_stb_i = 1'b1; wbi_adr_i = adr; wbi_we_i = we; wbi_sel_i = sel; wbi_bl_i = bl;
        end
        tick();
        last_d = side_d;
        n_checks++;
        if (arb_gnt !== (side_d ? 2'b10 : 2'b01) || wb_app_stb_o !== 1'b1 ||
            wb_app_adr_o !== adr || wb_app_we_o !== we || wb_app_sel_o !== sel ||
            wb_app_bl_o !== bl || arb_beat_cnt !== 10'd0) begin
            n_fail++;
            $display("FAIL %s grant: gnt=%b stb=%b adr=%h bl=%0d cnt=%0d, required gnt=%b stb=1 adr=%h bl=%0d cnt=0",
                     tag, arb_gnt, wb_app_stb_o, wb_app_adr_o, wb_app_bl_o, arb_beat_cnt,
                     side_d ? 2'b10 : 2'b01, adr, bl);
        end
        do_beats(side_d, nacks, 1'b1, gaps, tag);
        eff = (bl == 10'd0) ? 1 : int'(bl);
        if (nacks != eff) exp_err = 1'b1;
        if (side_d) wbd_stb_i = 1'b0;
        else        wbi_stb_i = 1'b0;
        n_checks++;
        if (arb_gnt !== 2'b00 || wb_app_stb_o !== 1'b0 || arb_burst_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s release: gnt=%b stb=%b err=%b, required gnt=00 stb=0 err=%b",
                     tag, arb_gnt, wb_app_stb_o, arb_burst_err, exp_err);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({arb_gnt, wb_app_stb_o, arb_beat_cnt, arb_burst_err, wbi_ack_o, wbd_ack_o} !== 16'd0 ||
            wb_app_adr_o !== 32'd0 || wbi_dat_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hold: gnt=%b stb=%b cnt=%0d err=%b expected all zero",
                     arb_gnt, wb_app_stb_o, arb_beat_cnt, arb_burst_err);
        end
        @(negedge mclk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({arb_gnt, wb_app_stb_o, arb_beat_cnt, arb_burst_err} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_release: gnt=%b stb=%b cnt=%0d err=%b expected all zero",
                     arb_gnt, wb_app_stb_o, arb_beat_cnt, arb_burst_err);
        end
    endtask

    task automatic test_tie();
        logic w;
        // Loser withdraws after each tie so only the tie rule decides.
        for (int r = 0; r < 5; r++) begin
            wbi_stb_i = 1'b1; wbi_bl_i = 10'd4; wbi_adr_i = $urandom;
            wbd_stb_i = 1'b1; wbd_bl_i = 10'd4; wbd_adr_i = $urandom;
            w = model_pick_d(1'b1, 1'b1);
            tick();
            last_d = w;
            n_checks++;
            if (arb_gnt !== (w ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL tie%0d grant: gnt=%b required %b", r, arb_gnt, w ? 2'b10 : 2'b01);
            end
            if (r < 4) begin
                if (w) wbi_stb_i = 1'b0;
                else   wbd_stb_i = 1'b0;
            end
            do_beats(w, 4, 1'b1, 1'b0, "tie");
            if (w) wbd_stb_i = 1'b0;
            else   wbi_stb_i = 1'b0;
            n_checks++;
            if (arb_gnt !== 2'b00) begin
                n_fail++;
                $display("FAIL tie%0d gap: gnt=%b required 00", r, arb_gnt);
            end
            if (r == 4) begin
                // Loser kept requesting: served right after the idle gap.
                tick();
                last_d = !w;
                n_checks++;
                if (arb_gnt !== (w ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL tie_loser grant: gnt=%b required %b", arb_gnt, w ? 2'b01 : 2'b10);
                end
                do_beats(!w, 4, 1'b1, 1'b0, "tie_loser");
                if (w) wbi_stb_i = 1'b0;
                else   wbd_stb_i = 1'b0;
                n_checks++;
                if (arb_gnt !== 2'b00 || arb_burst_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tie_loser release: gnt=%b err=%b required 00 0", arb_gnt, arb_burst_err);
                end
            end
        end
    endtask

    task automatic test_i_refill();
        burst(1'b0, 32'h0000_1080, 10'd32, 32, 1'b0, "i_refill");
    endtask

    task automatic test_bl0();
        burst(1'b1, $urandom, 10'd0, 1, 1'b0, "bl0");
    endtask

    task automatic test_abort();
        wbd_stb_i = 1'b1; wbd_bl_i = 10'd8; wbd_adr_i = $urandom;
        tick();
        last_d = 1'b1;
        wbi_stb_i = 1'b1; wbi_bl_i = 10'd6; wbi_adr_i = $urandom;
        n_checks++;
        if (arb_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL abort grant: gnt=%b required 10", arb_gnt);
        end
        do_beats(1'b1, 3, 1'b0, 1'b0, "abort_d");
        wbd_stb_i = 1'b0;
        #1;
        n_checks++;
        if (wb_app_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort stb_mirror: stb=%b required 0", wb_app_stb_o);
        end
        tick();
        n_checks++;
        if (arb_gnt !== 2'b00 || arb_burst_err !== 1'b0 || arb_beat_cnt !== 10'd3) begin
            n_fail++;
            $display("FAIL abort idle: gnt=%b err=%b cnt=%0d required 00 0 3", arb_gnt, arb_burst_err, arb_beat_cnt);
        end
        tick();
        last_d = 1'b0;
        n_checks++;
        if (arb_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL abort pending_i: gnt=%b required 01", arb_gnt);
        end
        do_beats(1'b0, 6, 1'b1, 1'b1, "abort_i");
        wbi_stb_i = 1'b0;
        n_checks++;
        if (arb_gnt !== 2'b00 || arb_burst_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort i_done: gnt=%b err=%b required 00 0", arb_gnt, arb_burst_err);
        end
    endtask

    task automatic test_prefill_err();
        burst(1'b0, $urandom, 10'h200, 511, 1'b0, "prefill");
        burst(1'b1, $urandom, 10'd5, 5, 1'b1, "after_err");
        burst(1'b0, $urandom, 10'd3, 3, 1'b0, "after_err2");
    endtask

    task automatic test_saturate();
        burst(1'b1, $urandom, 10'h3FF, 1030, 1'b0, "saturate");
    endtask

    task automatic test_reset_mid_burst();
        wbi_stb_i = 1'b1; wbi_bl_i = 10'd16; wbi_adr_i = 32'hDEAD_BEE0;
        tick();
        do_beats(1'b0, 5, 1'b0, 1'b0, "pre_reset");
        #2;
        wb_app_ack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        last_d  = 1'b0;
        n_checks++;
        if ({arb_gnt, wb_app_stb_o, arb_beat_cnt, arb_burst_err, wbi_ack_o, wbi_lack_o, wbd_ack_o} !== 17'd0 ||
            wb_app_adr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b stb=%b cnt=%0d err=%b iack=%b adr=%h expected all zero",
                     arb_gnt, wb_app_stb_o, arb_beat_cnt, arb_burst_err, wbi_ack_o, wb_app_adr_o);
        end
        wbi_stb_i = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wb_app_ack_i  = 1'b1;
            wb_app_lack_i = 1'($urandom);
            #1;
            n_checks++;
            if ({wbd_ack_o, wbi_ack_o, wbd_lack_o, wbi_lack_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL stray_ack%0d: acks=%b required 0000", k, {wbd_ack_o, wbi_ack_o, wbd_lack_o, wbi_lack_o});
            end
            tick();
            n_checks++;
            if (arb_gnt !== 2'b00 || arb_beat_cnt !== 10'd0) begin
                n_fail++;
                $display("FAIL stray_state%0d: gnt=%b cnt=%0d required 00 0", k, arb_gnt, arb_beat_cnt);
            end
        end
        wb_app_ack_i  = 1'b0;
        wb_app_lack_i = 1'b0;
    endtask

    task automatic test_random();
        logic       side;
        logic [9:0] bl;
        int         eff;
        int         n;
        for (int r = 0; r < 24; r++) begin
            side = 1'($urandom);
            bl   = 10'($urandom_range(0, 24));
            eff  = (bl == 10'd0) ? 1 : int'(bl);
            n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : eff;
            burst(side, $urandom, bl, n, 1'b1, "random");
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_err = 1'b0; last_d = 1'b0;
        rst_n = 1'b0;
        wbi_stb_i = 1'b0; wbi_adr_i = 32'd0; wbi_we_i = 1'b0; wbi_dat_i = 32'd0; wbi_sel_i = 4'd0; wbi_bl_i = 10'd0;
        wbd_stb_i = 1'b0; wbd_adr_i = 32'd0; wbd_we_i = 1'b0; wbd_dat_i = 32'd0; wbd_sel_i = 4'd0; wbd_bl_i = 10'd0;
        wb_app_dat_i = 32'd0; wb_app_ack_i = 1'b0; wb_app_lack_i = 1'b0;
        test_reset();
        test_tie();
        test_i_refill();
        test_bl0();
        test_abort();
        test_prefill_err();
        test_saturate();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
